// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes, applies the sign fix in FIX, and forces the
// RISC-V divide-by-zero and signed-overflow results.
// Optional build macro DIV_FAST_PATH_EN: trivial operations (divisor zero,
// signed overflow, |a| < |b|) bypass the iteration loop.
module alu_seq_divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state_q,  state_d;
    logic [1:0]      op_q,     op_d;
    logic            sa_q,     sa_d;
    logic            sb_q,     sb_d;
    logic            bzero_q,  bzero_d;
    logic            ovf_q,    ovf_d;
    logic            fast_q,   fast_d;
    logic [XLEN-1:0] a_q,      a_d;
    logic [XLEN-1:0] bmag_q,   bmag_d;
    logic [XLEN:0]   r_q,      r_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Start-time decode of the incoming request
    logic            in_signed;
    logic            in_sa;
    logic            in_sb;
    logic [XLEN-1:0] in_amag;
    logic [XLEN-1:0] in_bmag;
    logic            in_bzero;
    logic            in_ovf;

    // One restoring step; the extra top bit makes the trial sign explicit
    logic [XLEN+1:0] trial;
    logic            trial_ok;

    // Decode operands and compute magnitudes for the start edge
    always_comb begin
        in_signed = ~i_op[0];
        in_sa     = i_a[XLEN-1] & in_signed;
        in_sb     = i_b[XLEN-1] & in_signed;
        in_amag   = in_sa ? (~i_a + 1'b1) : i_a;
        in_bmag   = in_sb ? (~i_b + 1'b1) : i_b;
        in_bzero  = (i_b == '0);
        in_ovf    = in_signed && (i_a == MIN_NEG) && (i_b == '1);
        trial     = {r_q, quo_q[XLEN-1]} - {2'b00, bmag_q};
        trial_ok  = ~trial[XLEN+1];
    end

    // Next-state, datapath and result selection
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        ovf_d    = ovf_q;
        fast_d   = fast_q;
        a_d      = a_q;
        bmag_d   = bmag_q;
        r_d      = r_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    bzero_d = in_bzero;
                    ovf_d   = in_ovf;
                    a_d     = i_a;
                    bmag_d  = in_bmag;
                    r_d     = '0;
                    quo_d   = in_amag;
                    cnt_d   = '0;
                    fast_d  = 1'b0;
`ifdef DIV_FAST_PATH_EN
                    // Trivial operations preload Q=0, R=|a| and spend a
                    // single edge in CALC instead of XLEN iterations.
                    if (in_bzero || in_ovf || (in_amag < in_bmag)) begin
                        fast_d = 1'b1;
                        quo_d  = '0;
                        r_d    = {1'b0, in_amag};
                    end
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (fast_q) begin
                    state_d = S_FIX;
                end else begin
                    quo_d = {quo_q[XLEN-2:0], trial_ok};
                    r_d   = trial_ok ? trial[XLEN:0]
                                     : {r_q[XLEN-1:0], quo_q[XLEN-1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                case (op_q)
                    2'b00:   result_d = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
                    2'b01:   result_d = quo_q;
                    2'b10:   result_d = sa_q ? (~r_q[XLEN-1:0] + 1'b1) : r_q[XLEN-1:0];
                    default: result_d = r_q[XLEN-1:0];
                endcase
                // Architectural special cases take priority over the datapath
                if (bzero_q) begin
                    result_d = op_q[1] ? a_q : '1;
                end else if (ovf_q) begin
                    result_d = op_q[1] ? '0 : MIN_NEG;
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
            fast_q   <= 1'b0;
            a_q      <= '0;
            bmag_q   <= '0;
            r_q      <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            ovf_q    <= ovf_d;
            fast_q   <= fast_d;
            a_q      <= a_d;
            bmag_q   <= bmag_d;
            r_q      <= r_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        o_busy   = (state_q != S_IDLE);
        o_done   = (state_q == S_DONE);
        o_result = result_q;
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Randomized self-checking bench for alu_seq_divider against a RISC-V
// arithmetic reference model. Honours DIV_FAST_PATH_EN for latency.
module tb_alu_seq_divider;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    alu_seq_divider #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic ovf;
        ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_NEG
                                : 32'($signed(a) / $signed(b));
            2'b01:   ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   ref_result = (b == 0) ? a : ovf ? 32'h0
                                : 32'($signed(a) % $signed(b));
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic longint magnitude(input logic [31:0] v, input bit is_signed);
        if (is_signed && v[31]) magnitude = 64'sd4294967296 - longint'(v);
        else magnitude = longint'(v);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        ref_latency = 33;
`ifdef DIV_FAST_PATH_EN
        if (b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) ||
            magnitude(a, !op[0]) < magnitude(b, !op[0]))
            ref_latency = 2;
`endif
    endfunction

    // One complete operation; glitch pulses i_start at E5 and changes i_a at E6
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit glitch);
        bit got;
        int lat;
        logic [31:0] exp_r;
        exp_r = ref_result(op, a, b);
        got = 0;
        lat = 0;
        @(negedge i_clk);
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_start", {31'b0, o_busy}, 32'd1);
        for (int n = 1; n <= 40 && !got; n++) begin
            if (glitch && n == 5) i_start = 1'b1;
            if (glitch && n == 6) begin i_start = 1'b0; i_a = $urandom; end
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_done) begin got = 1; lat = n; end
        end
        i_start = 1'b0;
        check("done_seen", {31'b0, got}, 32'd1);
        if (got) begin
            check("latency", lat, ref_latency(op, a, b));
            check("result", o_result, exp_r);
            check("busy_in_done", {31'b0, o_busy}, 32'd1);
            @(negedge i_clk);
            check("done_width", {31'b0, o_done}, 32'd0);
            check("busy_after_done", {31'b0, o_busy}, 32'd0);
            check("result_hold", o_result, exp_r);
        end
        $display("op=%0d a=0x%h b=0x%h result=0x%h expected=0x%h latency=%0d",
                 op, a, b, o_result, exp_r, lat);
    endtask

    initial begin
        int pulses;
        int last_k;
        int k;
        int width_err;
        int done_cnt;
        bit prev;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_result", o_result, 32'd0);
        i_rst = 1'b0;

        // Directed cases
        run_op(2'b01, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 0);
        run_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, 0);
        for (int op = 0; op < 4; op++) run_op(2'(op), 32'h1234_5678, 32'h0, 0);
        run_op(2'b01, 32'd1000, 32'd10, 1);

        // Reset in the middle of an operation
        @(negedge i_clk);
        i_op = 2'b01; i_a = 32'd12345; i_b = 32'd3; i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        $display("reset mid-operation: done pulses after reset=%0d", done_cnt);

        // Back-to-back with i_start held high
        @(negedge i_clk);
        i_op = 2'b01; i_a = 32'd50; i_b = 32'd5; i_start = 1'b1;
        pulses = 0; last_k = 0; k = 0; width_err = 0; prev = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge i_clk);
            k++;
            @(negedge i_clk);
            if (o_done) begin
                pulses++;
                check("b2b_result", o_result, 32'd10);
                if (pulses > 1) check("b2b_spacing", k - last_k, 35);
                last_k = k;
            end
            if (o_done && prev) width_err++;
            prev = o_done;
        end
        i_start = 1'b0;
        check("b2b_pulses", pulses, 3);
        check("b2b_width", width_err, 0);
        $display("back-to-back: pulses=%0d width_errors=%0d", pulses, width_err);
        for (int c = 0; c < 50 && o_busy; c++) @(negedge i_clk);
        check("b2b_drained", {31'b0, o_busy}, 32'd0);

        // Randomized operations
        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra, rb;
            int mode;
            mode = $urandom_range(0, 5);
            ra = $urandom;
            rb = $urandom;
            case (mode)
                1: rb = 32'($urandom_range(0, 15));
                2: rb = 32'h0;
                3: begin ra = 32'($urandom_range(0, 99)); rb = 32'($urandom_range(100, 100000)); end
                4: rb = 32'h0 - 32'($urandom_range(1, 9));
                5: begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M ops DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU.
- The core issues a start pulse and waits for a one-cycle done pulse.
- Internally it operates on magnitudes, applies a sign fix afterwards, and forces the RISC-V special-case results.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- i_clk  input  1  clock; all logic on the rising edge
- i_rst  input  1  synchronous active-high reset
- i_start  input  1  request; sampled only in IDLE
- i_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- i_a  input  XLEN  dividend
- i_b  input  XLEN  divisor
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  single-cycle pulse; o_result is valid while high
- o_result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); holds until the next o_done

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
  - Reset forces state=IDLE, o_busy=0, o_done=0, o_result=0 and clears all internal registers.
  - Reset mid-operation aborts the operation; no o_done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On i_start=1 at edge E0, latch i_op, signed flag (op DIV/REM), sa=i_a[XLEN-1]&signed, sb=i_b[XLEN-1]&signed.
  - Also latch |a| and |b|, using two's-complement negate when the sign is set; |−2^31| = 0x8000_0000 unsigned.
  - Clear the remainder register R (XLEN+1 bits) and the iteration counter. Go to CALC.
- CALC: one iteration per edge, MSB first, exactly XLEN edges (E1..E32).
  - Shift {R,Q} left by 1.
  - Trial T = R − |b| at XLEN+1 bits.
  - If T is non-negative: R=T, Q[0]=1. Otherwise restore R and set Q[0]=0.
  - When the counter reaches XLEN−1, go to FIX.
- FIX (edge E33): register o_result and go to DONE.
  - DIVU: Q.
  - REMU: R.
  - DIV: (sa^sb) ? −Q : Q.
  - REM: sa ? −R : R.
  - Divide by zero (latched b==0) overrides the above:
    - DIV/DIVU result = 0xFFFF_FFFF.
    - REM/REMU result = original i_a.
  - Signed overflow (a=0x8000_0000, b=0xFFFF_FFFF, DIV/REM): DIV=0x8000_0000, REM=0. The natural datapath yields this; it must also be explicitly guaranteed.
- DONE: o_done=1 for exactly this cycle. Next edge returns to IDLE.
- Latency: o_done is high during the cycle after E33, i.e. 33 edges after the start edge. o_busy is high from after E0 until after E34.
- i_start while o_busy=1 is ignored. Operands are only sampled at E0; later changes to i_a/i_b/i_op have no effect.
- Back-to-back: i_start may be asserted in the cycle where o_done=1. It is accepted at the next edge only if state is IDLE, so the earliest restart is the edge after DONE→IDLE.
- All arithmetic is modulo 2^XLEN. No X propagation from unused bits.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - In IDLE, if the divisor is zero or signed overflow is detected at start, skip CALC and go directly to FIX. Forced results are identical; o_done appears 2 edges after start.
  - Also, if |a| < |b| (unsigned magnitude compare), skip CALC with Q=0, R=|a|; the same sign fix applies.
- Undefined: every operation takes the full 33-edge path. Special results are applied in FIX only.
- Results must be bit-identical in both builds; only latency differs.

Test Plan:
- DIVU a=100, b=7: o_done after 33 edges, o_result=14. Then REMU with the same operands -> 2.
- DIV a=−100 (0xFFFF_FF9C), b=7 -> 0xFFFF_FFF2 (−14). REM with the same operands -> 0xFFFF_FFFE (−2). REM a=100, b=−7 -> 2.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000. REM with the same operands -> 0.
- DIVU/DIV a=0x1234_5678, b=0 -> 0xFFFF_FFFF. REM/REMU with the same operands -> 0x1234_5678.
  - With DIV_FAST_PATH_EN: o_done 2 edges after start.
  - Without it: 33 edges.
- Start DIVU 1000/10, pulse i_start again at edge 5, and change i_a at edge 6 -> single o_done, result 100.
  - Then assert i_rst at edge 10 of a new op -> no o_done; o_busy=0 and o_result=0 after the reset edge.
- Back-to-back: hold i_start high continuously with DIVU 50/5 -> o_done pulses every 35 edges, each pulse exactly 1 cycle wide, result 10.
